alu_result_queue: RTL
=====================

# alu_result_queue

Buffers results leaving the execute-stage ALU and forwards them to register-file writeback under a valid/ready handshake. Each accepted entry carries:

- the 64-bit ALU result,
- the destination register index,
- the opcode that produced the result,
- status flags the ALU itself does not produce (zero, negative, wide).

The queue decouples ALU issue from writeback stalls, so the ALU can keep producing while writeback is blocked.

## Interface

Parameters:
- DATA_WIDTH, 64: result width; matches ALU output width.
- OP_CODE_WIDTH, 4: opcode width.
- REG_ADDR_WIDTH, 5: destination register index width.
- DEPTH, 4: entry count; power of two, ≥2.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  queue can accept this cycle.
- in_data  input  DATA_WIDTH  ALU result.
- in_op_code  input  OP_CODE_WIDTH  opcode that produced in_data.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  writeback consumes the head this cycle.
- out_data  output  DATA_WIDTH  head result.
- out_op_code  output  OP_CODE_WIDTH  head opcode.
- out_rd  output  REG_ADDR_WIDTH  head destination.
- out_flags  output  3  head flags {wide, negative, zero}.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation

Handshake:
- Push = in_valid && in_ready.
- Pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is independent of out_ready; there is no full-bypass.
- out_valid = (count != 0).

Flags are computed at push time from in_data and stored with the entry:
- zero = (in_data == 0).
- negative = in_data[DATA_WIDTH-1].
- wide = |in_data[DATA_WIDTH-1:DATA_WIDTH/2], i.e. the result does not fit the 32-bit datapath.

Storage and pointers:
- Storage is a circular array.
- wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- count tracks occupancy.

Per-cycle update:
- Push only: write entry at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count−1.
- Push and pop in the same cycle: both pointers advance, count unchanged. This is legal at any non-full, non-empty occupancy.
- Full: in_ready=0, so no push can occur; a pop frees a slot for the following cycle.
- Empty: out_valid=0 and out_ready is ignored; in_valid that cycle is accepted normally.
- in_valid while not ready: no state change. Upstream must hold its data.

Outputs and reset:
- out_* fields are driven from the entry at rd_ptr. They are don't-care while out_valid=0, but the implementation must not produce X after reset.
- Reset values: count=0, in_ready=1, out_valid=0, out_data=0, out_op_code=0, out_rd=0, out_flags=0, wr_ptr=rd_ptr=0.
- Reset asserted mid-operation discards all entries at that edge; in-flight push/pop that cycle are ignored.

## Timing

- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N. There is no combinational in-to-out path.
- in_ready and out_valid are pure functions of registered count, with no combinational dependence on in_valid or out_ready.
- Throughput: one push and one pop per cycle sustained.
- First push after reset deassertion is accepted in the first cycle with rst=0.

## Configuration

- Macro: ALU_RESULT_QUEUE_FLAGS_EN.
- Defined: flags are generated and stored per entry as described above.
- Undefined: flag logic and storage are omitted, and out_flags is tied to 3'b000. All other behaviour is identical.

## Structure

Shared package alu_pkg contains:
- the opcode enum (ALU_ADD=4'b0000, ALU_SUB, ALU_MUL, ALU_DIV, ALU_SLL, ALU_SRL, ALU_LAND, ALU_LOR, ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_NOR, ALU_XNOR, ALU_GT, ALU_LT=4'b1111);
- the packed struct alu_flags_t {wide, negative, zero};
- the packed struct alu_result_t {data, op_code, rd, flags}.

The queue stores alu_result_t entries. Flag computation lives in one combinational sub-module, alu_flag_gen, which is instantiated only under ALU_RESULT_QUEUE_FLAGS_EN.

## Test plan

- Reset then idle: count=0, in_ready=1, out_valid=0, all out_* zero.
- Push 0x0000_0000_0000_0000 (op 0000, rd 3) with out_ready=0: next cycle out_valid=1, out_rd=3, out_flags=3'b001, count=1.
- Push 0xFFFF_FFFF_FFFF_FFFE then 0x0000_0001_0000_0000, then pop both: flags 3'b110, then 3'b100, in FIFO order.
- Fill DEPTH=4 entries with out_ready=0:
  - count=4 and in_ready=0;
  - a held in_valid is not accepted;
  - one pop raises in_ready in the next cycle.
- Simultaneous push/pop at count=2 for 10 cycles with incrementing data: count stays 2, output sequence is in order, and pointers wrap correctly.
- Reset asserted with count=3 while pushing: next cycle count=0, out_valid=0, and the pushed entry is lost. With the macro undefined, out_flags=0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, flag and result types
package alu_pkg;

  localparam int ALU_DATA_W = 64;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_RD_W   = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_DIV  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_LAND = 4'b0110,
    ALU_LOR  = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_NAND = 4'b1011,
    ALU_NOR  = 4'b1100,
    ALU_XNOR = 4'b1101,
    ALU_GT   = 4'b1110,
    ALU_LT   = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic wide;
    logic negative;
    logic zero;
  } alu_flags_t;

  // op_code is kept as raw bits so unknown encodings pass through untouched
  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_OP_W-1:0]   op_code;
    logic [ALU_RD_W-1:0]   rd;
    alu_flags_t            flags;
  } alu_result_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational zero/negative/wide flags for an ALU result
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output alu_flags_t            flags_o
);

  // wide means the upper half is non-zero, i.e. the value overflows the 32-bit path
  always_comb begin
    flags_o          = '0;
    flags_o.zero     = (data_i == '0);
    flags_o.negative = data_i[DATA_WIDTH-1];
    flags_o.wide     = |data_i[DATA_WIDTH-1:DATA_WIDTH/2];
  end

endmodule

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - ALU result FIFO to writeback; flags under ALU_RESULT_QUEUE_FLAGS_EN
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_W,
  parameter int OP_CODE_WIDTH  = ALU_OP_W,
  parameter int REG_ADDR_WIDTH = ALU_RD_W,
  parameter int DEPTH          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [OP_CODE_WIDTH-1:0]   in_op_code,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [OP_CODE_WIDTH-1:0]   out_op_code,
  output logic [REG_ADDR_WIDTH-1:0]  out_rd,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_result_t       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  alu_flags_t        in_flags;
  alu_result_t       in_entry;
  alu_result_t       head;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

`ifdef ALU_RESULT_QUEUE_FLAGS_EN
  alu_flag_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_flag_gen (
    .data_i  (in_data),
    .flags_o (in_flags)
  );
`else
  // flags field is written constant zero, so its storage folds away
  assign in_flags = '0;
`endif

  // pack the incoming beat into a stored entry
  always_comb begin
    in_entry         = '0;
    in_entry.data    = in_data;
    in_entry.op_code = in_op_code;
    in_entry.rd      = in_rd;
    in_entry.flags   = in_flags;
  end

  // pointer and occupancy next-state; push+pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // state registers; storage is cleared on reset so the head never reads X
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // head entry drives the writeback side directly from storage
  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_data    = head.data;
    out_op_code = head.op_code;
    out_rd      = head.rd;
    out_flags   = head.flags;
  end

endmodule
